// File: rtl/wb_sender_v_pkg.sv
// Shared types for the lane write-back sender: entry layout, FIFO depth and FSM states.
package wb_sender_v_pkg;

  localparam int unsigned WB_FIFO_DEPTH = 4;
  localparam int unsigned INDEX_W       = 6;
  localparam int unsigned DATA_W        = 32;

  typedef logic [INDEX_W-1:0] index_t;
  typedef logic [DATA_W-1:0]  data_t;

  // One queued result: path select plus destination register and payload.
  typedef struct packed {
    logic       remote;
    logic [3:0] offset;
    index_t     idx;
    data_t      data;
  } wb_entry_t;

  typedef enum logic [1:0] {
    WB_IDLE,
    WB_ISSUE,
    WB_XFER
  } fsm_wb_t;

endpackage

// File: rtl/wb_sender_v_fifo.sv
// Result FIFO for the write-back sender: power-of-two depth, occupancy count, full/empty flags.
module wb_sender_v_fifo
  import wb_sender_v_pkg::*;
#(
  parameter int unsigned DEPTH = WB_FIFO_DEPTH,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = $clog2(DEPTH) + 1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  wb_entry_t       wdata,
  output wb_entry_t       rdata,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            empty
);

  wb_entry_t       mem [DEPTH];
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic            push_ok;
  logic            pop_ok;

  // Guard against a push into a full FIFO or a pop from an empty one.
  always_comb begin
    full    = (count == CntW'(DEPTH));
    empty   = (count == '0);
    push_ok = push & ~full;
    pop_ok  = pop & ~empty;
    rdata   = mem[rd_ptr];
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/wb_sender_v.sv
// Per-lane write-back sender: queues exec results and issues each once, either as a local
// register-file write or as a valid/ready transfer onto the inter-lane write-back bus.
module wb_sender_v
  import wb_sender_v_pkg::*;
#(
  parameter int unsigned NUM_LANES   = 16,
  parameter int unsigned WIDTH_LANES = $clog2(NUM_LANES),
  parameter int unsigned LANE_ID     = 0,
  parameter int unsigned DEPTH       = WB_FIFO_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   I_Stall,
  input  logic                   I_Valid,
  input  index_t                 I_Index,
  input  data_t                  I_Data,
  input  logic [4:0]             I_Sel_Path_WB,
  input  logic                   I_Lane_Ready,
  output logic                   O_WB_Req,
  output index_t                 O_WB_Index,
  output data_t                  O_WB_Data,
  output logic                   O_Lane_Valid,
  output logic [WIDTH_LANES-1:0] O_Lane_Dst,
  output index_t                 O_Lane_Index,
  output data_t                  O_Lane_Data_WB,
  output logic                   O_Full,
  output logic                   O_Overflow
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fsm_wb_t         state_q, state_d;
  logic            overflow_q;
  logic            push, pop;
  logic            wb_req, lane_valid;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] count;
  logic            count_gt1;
  wb_entry_t       wdata, head;
  logic [WIDTH_LANES-1:0] lane_dst;

  assign wdata = '{remote: I_Sel_Path_WB[4], offset: I_Sel_Path_WB[3:0],
                   idx: I_Index, data: I_Data};
  assign push  = I_Valid & ~fifo_full;

  wb_sender_v_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (wdata),
    .rdata (head),
    .count (count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state_q <= WB_IDLE;
    else       state_q <= state_d;
  end

  // Overflow is sticky until reset: a push was attempted with no free slot.
  always_ff @(posedge clock) begin
    if (reset)                      overflow_q <= 1'b0;
    else if (I_Valid && fifo_full)  overflow_q <= 1'b1;
  end

  // Next-state and issue control; a pop leaves work behind if another entry or a push exists.
  always_comb begin
    state_d    = state_q;
    wb_req     = 1'b0;
    lane_valid = 1'b0;
    pop        = 1'b0;
    count_gt1  = (count > CntW'(1));
    unique case (state_q)
      WB_IDLE: begin
        if (push) state_d = WB_ISSUE;
      end
      WB_ISSUE: begin
        if (fifo_empty) begin
          if (!push) state_d = WB_IDLE;
        end else if (head.remote) begin
          state_d = WB_XFER;
        end else if (!I_Stall) begin
          wb_req  = 1'b1;
          pop     = 1'b1;
          state_d = (push || count_gt1) ? WB_ISSUE : WB_IDLE;
        end
      end
      WB_XFER: begin
        lane_valid = ~fifo_empty;
        if (lane_valid && I_Lane_Ready) begin
          pop     = 1'b1;
          state_d = (push || count_gt1) ? WB_ISSUE : WB_IDLE;
        end
      end
      default: state_d = WB_IDLE;
    endcase
  end

  // Target lane wraps modulo the lane count by dropping the carry.
  assign lane_dst = WIDTH_LANES'(LANE_ID) + WIDTH_LANES'(head.offset);

  // Outputs forced to zero while reset is held; fields are zero unless their strobe is high.
  always_comb begin
    O_WB_Req       = wb_req & ~reset;
    O_WB_Index     = O_WB_Req ? head.idx : '0;
    O_WB_Data      = O_WB_Req ? head.data : '0;
    O_Lane_Valid   = lane_valid & ~reset;
    O_Lane_Dst     = O_Lane_Valid ? lane_dst : '0;
    O_Lane_Index   = O_Lane_Valid ? head.idx : '0;
    O_Lane_Data_WB = O_Lane_Valid ? head.data : '0;
    O_Full         = ~reset & (count >= CntW'(DEPTH - 1));
    O_Overflow     = ~reset & overflow_q;
  end

endmodule

// File: tb/tb_wb_sender_v.sv
// Directed self-checking bench for wb_sender_v (LANE_ID=14, DEPTH=4).
module tb_wb_sender_v;
  import wb_sender_v_pkg::*;

  logic       clock = 1'b0;
  logic       reset;
  logic       I_Stall, I_Valid, I_Lane_Ready;
  index_t     I_Index;
  data_t      I_Data;
  logic [4:0] I_Sel_Path_WB;
  logic       O_WB_Req, O_Lane_Valid, O_Full, O_Overflow;
  index_t     O_WB_Index, O_Lane_Index;
  data_t      O_WB_Data, O_Lane_Data_WB;
  logic [3:0] O_Lane_Dst;

  int checks = 0;
  int passes = 0;

  always #5 clock = ~clock;

  wb_sender_v #(
    .NUM_LANES (16),
    .LANE_ID   (14),
    .DEPTH     (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .I_Stall        (I_Stall),
    .I_Valid        (I_Valid),
    .I_Index        (I_Index),
    .I_Data         (I_Data),
    .I_Sel_Path_WB  (I_Sel_Path_WB),
    .I_Lane_Ready   (I_Lane_Ready),
    .O_WB_Req       (O_WB_Req),
    .O_WB_Index     (O_WB_Index),
    .O_WB_Data      (O_WB_Data),
    .O_Lane_Valid   (O_Lane_Valid),
    .O_Lane_Dst     (O_Lane_Dst),
    .O_Lane_Index   (O_Lane_Index),
    .O_Lane_Data_WB (O_Lane_Data_WB),
    .O_Full         (O_Full),
    .O_Overflow     (O_Overflow)
  );

  // Inputs change 1 time unit after the rising edge; outputs are read at the falling edge.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic sample();
    @(negedge clock);
  endtask

  task automatic drive(input logic v, input logic [4:0] sel, input index_t idx, input data_t d);
    I_Valid       = v;
    I_Sel_Path_WB = sel;
    I_Index       = idx;
    I_Data        = d;
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    I_Stall      = 1'b0;
    I_Lane_Ready = 1'b0;
    drive(1'b0, 5'd0, '0, '0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    next_cycle();
  endtask

  task automatic test_reset();
    reset        = 1'b1;
    I_Stall      = 1'b0;
    I_Lane_Ready = 1'b1;
    drive(1'b1, 5'b1_0001, 6'd3, 32'h1234);
    sample();
    checks++;
    if ({O_WB_Req, O_Lane_Valid, O_Full, O_Overflow} !== 4'b0) begin
      $display("FAIL reset_during: req/valid/full/ovf=%b required 0000",
               {O_WB_Req, O_Lane_Valid, O_Full, O_Overflow});
    end else passes++;
    next_cycle();
    reset = 1'b0;
    drive(1'b0, 5'd0, '0, '0);
    sample();
    checks++;
    if ({O_WB_Req, O_Lane_Valid, O_Full, O_Overflow, O_WB_Index, O_WB_Data,
         O_Lane_Dst, O_Lane_Index, O_Lane_Data_WB} !== '0) begin
      $display("FAIL reset_after: req=%b valid=%b full=%b ovf=%b required all outputs 0",
               O_WB_Req, O_Lane_Valid, O_Full, O_Overflow);
    end else passes++;
    next_cycle();
  endtask

  task automatic test_local_burst();
    logic   exp_req;
    index_t exp_idx;
    data_t  exp_data;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      if (c < 3) drive(1'b1, 5'd0, index_t'(c + 1), data_t'(32'hA + c));
      else       drive(1'b0, 5'd0, '0, '0);
      sample();
      exp_req  = (c >= 1 && c <= 3);
      exp_idx  = exp_req ? index_t'(c) : '0;
      exp_data = exp_req ? data_t'(32'hA + c - 1) : '0;
      checks++;
      if (O_WB_Req !== exp_req || O_WB_Index !== exp_idx || O_WB_Data !== exp_data) begin
        $display("FAIL burst_c%0d: req=%b idx=%0d data=%h required req=%b idx=%0d data=%h",
                 c, O_WB_Req, O_WB_Index, O_WB_Data, exp_req, exp_idx, exp_data);
      end else passes++;
      next_cycle();
    end
  endtask

  task automatic test_stall();
    logic exp_req;
    do_reset();
    for (int c = 0; c < 7; c++) begin
      I_Stall = (c < 4);
      if (c == 0) drive(1'b1, 5'd0, 6'd5, 32'h55);
      else        drive(1'b0, 5'd0, '0, '0);
      sample();
      exp_req = (c == 4);
      checks++;
      if (O_WB_Req !== exp_req || (exp_req && O_WB_Index !== 6'd5)) begin
        $display("FAIL stall_c%0d: req=%b idx=%0d required req=%b idx=5",
                 c, O_WB_Req, O_WB_Index, exp_req);
      end else passes++;
      next_cycle();
    end
  endtask

  task automatic test_remote();
    logic exp_v;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      I_Lane_Ready = (c == 7);
      if (c == 0) drive(1'b1, 5'b1_0011, 6'd7, 32'hDEAD_BEEF);
      else        drive(1'b0, 5'd0, '0, '0);
      sample();
      exp_v = (c >= 2 && c <= 7);
      checks++;
      if (O_Lane_Valid !== exp_v || O_WB_Req !== 1'b0 ||
          (exp_v && (O_Lane_Dst !== 4'd1 || O_Lane_Index !== 6'd7 ||
                     O_Lane_Data_WB !== 32'hDEAD_BEEF))) begin
        $display("FAIL remote_c%0d: valid=%b dst=%0d idx=%0d data=%h req=%b required valid=%b dst=1 idx=7 data=deadbeef req=0",
                 c, O_Lane_Valid, O_Lane_Dst, O_Lane_Index, O_Lane_Data_WB, O_WB_Req, exp_v);
      end else passes++;
      next_cycle();
    end
  endtask

  task automatic test_overflow();
    logic   exp_full, exp_ovf, exp_req;
    index_t exp_idx;
    do_reset();
    for (int c = 0; c < 11; c++) begin
      I_Stall = (c < 6);
      if (c < 5) drive(1'b1, 5'd0, index_t'(c + 1), data_t'(32'h100 + c + 1));
      else       drive(1'b0, 5'd0, '0, '0);
      sample();
      exp_full = (c >= 3 && c <= 7);
      exp_ovf  = (c >= 5);
      exp_req  = (c >= 6 && c <= 9);
      exp_idx  = exp_req ? index_t'(c - 5) : '0;
      checks++;
      if (O_Full !== exp_full || O_Overflow !== exp_ovf || O_WB_Req !== exp_req ||
          O_WB_Index !== exp_idx) begin
        $display("FAIL overflow_c%0d: full=%b ovf=%b req=%b idx=%0d required full=%b ovf=%b req=%b idx=%0d",
                 c, O_Full, O_Overflow, O_WB_Req, O_WB_Index, exp_full, exp_ovf, exp_req, exp_idx);
      end else passes++;
      next_cycle();
    end
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    sample();
    checks++;
    if (O_Overflow !== 1'b0) begin
      $display("FAIL overflow_clear: ovf=%b required 0", O_Overflow);
    end else passes++;
    next_cycle();
  endtask

  task automatic test_interleaved();
    logic   exp_req, exp_v;
    index_t exp_idx;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      I_Lane_Ready = (c == 5);
      case (c)
        0:       drive(1'b1, 5'b0_0000, 6'd1, 32'h11);
        1:       drive(1'b1, 5'b1_0010, 6'd2, 32'h22);
        2:       drive(1'b1, 5'b0_0000, 6'd3, 32'h33);
        default: drive(1'b0, 5'd0, '0, '0);
      endcase
      sample();
      exp_req = (c == 1 || c == 6);
      exp_idx = (c == 1) ? 6'd1 : 6'd3;
      exp_v   = (c >= 3 && c <= 5);
      checks++;
      if (O_WB_Req !== exp_req || (exp_req && O_WB_Index !== exp_idx) ||
          O_Lane_Valid !== exp_v ||
          (exp_v && (O_Lane_Dst !== 4'd0 || O_Lane_Index !== 6'd2 ||
                     O_Lane_Data_WB !== 32'h22))) begin
        $display("FAIL interleave_c%0d: req=%b idx=%0d valid=%b dst=%0d lidx=%0d required req=%b idx=%0d valid=%b dst=0 lidx=2",
                 c, O_WB_Req, O_WB_Index, O_Lane_Valid, O_Lane_Dst, O_Lane_Index,
                 exp_req, exp_idx, exp_v);
      end else passes++;
      next_cycle();
    end
  endtask

  task automatic test_reset_xfer();
    do_reset();
    drive(1'b1, 5'b1_0000, 6'd9, 32'h99);
    next_cycle();
    drive(1'b1, 5'b0_0000, 6'd10, 32'hAA);
    next_cycle();
    drive(1'b0, 5'd0, '0, '0);
    sample();
    checks++;
    if (O_Lane_Valid !== 1'b1 || O_Lane_Dst !== 4'd14 || O_Lane_Index !== 6'd9) begin
      $display("FAIL xfer_self: valid=%b dst=%0d idx=%0d required valid=1 dst=14 idx=9",
               O_Lane_Valid, O_Lane_Dst, O_Lane_Index);
    end else passes++;
    next_cycle();
    reset = 1'b1;
    sample();
    checks++;
    if ({O_WB_Req, O_Lane_Valid, O_Full, O_Overflow} !== 4'b0) begin
      $display("FAIL xfer_reset_during: req/valid/full/ovf=%b required 0000",
               {O_WB_Req, O_Lane_Valid, O_Full, O_Overflow});
    end else passes++;
    next_cycle();
    reset        = 1'b0;
    I_Lane_Ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      sample();
      checks++;
      if ({O_WB_Req, O_Lane_Valid, O_Full, O_Overflow, O_WB_Index, O_WB_Data,
           O_Lane_Dst, O_Lane_Index, O_Lane_Data_WB} !== '0) begin
        $display("FAIL xfer_after_reset_c%0d: req=%b valid=%b full=%b ovf=%b required all outputs 0",
                 c, O_WB_Req, O_Lane_Valid, O_Full, O_Overflow);
      end else passes++;
      next_cycle();
    end
  endtask

  initial begin
    reset        = 1'b1;
    I_Stall      = 1'b0;
    I_Lane_Ready = 1'b0;
    drive(1'b0, 5'd0, '0, '0);
    next_cycle();
    test_reset();
    test_local_burst();
    test_stall();
    test_remote();
    test_overflow();
    test_interleaved();
    test_reset_xfer();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/wb_sender_v.md
# wb_sender_v

Per-lane write-back transmitter for the vector unit; the producer end of the write-back path that the lane network and bypass buffer consume. It accepts execution results (index, data, path select), queues them in a small FIFO, and issues each result once. A result goes either as a local register-file write, which also feeds the bypass buffer, or as a transfer onto the inter-lane write-back lane bus with a valid/ready handshake. It sits between the exec-unit output stage and the lane's register file / network block.

## Interface
- NUM_LANES, 16, lanes in the vector unit
- WIDTH_LANES, $clog2(NUM_LANES), lane-offset width
- LANE_ID, 0, this lane's index
- DEPTH, WB_FIFO_DEPTH (4), result FIFO entries; power of two, ≥2

Ports:
- clock  in  1  single clock
- reset  in  1  synchronous, active-high
- I_Stall  in  1  pipeline stall; blocks local write issue
- I_Valid  in  1  exec result valid
- I_Index  in  index_t  destination register index
- I_Data  in  data_t  result data
- I_Sel_Path_WB  in  5  [4]=remote, [3:0]=lane offset
- I_Lane_Ready  in  1  lane bus accepts transfer
- O_WB_Req  out  1  local RF write strobe (one cycle per entry)
- O_WB_Index  out  index_t  local write index
- O_WB_Data  out  data_t  local write data
- O_Lane_Valid  out  1  remote transfer valid
- O_Lane_Dst  out  WIDTH_LANES  target lane = (LANE_ID + offset) mod NUM_LANES
- O_Lane_Index  out  index_t  remote write index
- O_Lane_Data_WB  out  data_t  remote write data
- O_Full  out  1  upstream must hold I_Valid low next cycle
- O_Overflow  out  1  sticky: push attempted while FIFO full

## Operation
- Push: I_Valid=1 and count<DEPTH writes {remote, offset, index, data} at wr_ptr.
- If I_Valid=1 and count==DEPTH, nothing is written and O_Overflow is set. O_Overflow clears only on reset.
- FSM: IDLE, ISSUE, XFER.
  - IDLE: FIFO empty. Go to ISSUE when count becomes nonzero.
  - ISSUE, head local: if !I_Stall, pulse O_WB_Req with the head fields and pop. Stay in ISSUE if entries remain after the pop, else go to IDLE. If I_Stall, hold with O_WB_Req=0.
  - ISSUE, head remote: go to XFER; no pop.
  - XFER: O_Lane_Valid=1 with the head fields, which stay stable. On I_Lane_Ready=1, pop; go to ISSUE if entries remain, else IDLE. I_Stall does not affect XFER.
- Offset arithmetic: WIDTH_LANES-bit add; the carry is dropped (wrap-around). Offset 0 with remote=1 is a legal self-transfer on the bus.
- Simultaneous push and pop: count unchanged; pointers both advance and wrap mod DEPTH.
- O_Full = (count ≥ DEPTH-1), i.e. one entry of slack. This covers the one-cycle upstream response.
- Reset (also mid-transfer): pointers, count and FSM clear to IDLE; O_Overflow clears; all in-flight entries are discarded.

## Timing
- Every output is 0 during reset and in the cycle after it.
- Push at edge N: head is visible at N+1.
  - Local, unstalled: O_WB_Req high during cycle N+1 (1-cycle latency).
  - Remote: O_Lane_Valid high from N+2 (ISSUE→XFER adds one cycle).
- Sustained local throughput is 1 entry/cycle with back-to-back O_WB_Req. Remote throughput is ≤1 per 2 cycles.
- O_Lane_Valid never drops without I_Lane_Ready. Data, Dst and Index are held stable while Valid=1 and Ready=0.
- O_WB_Req is registered-state qualified and combinationally gated by I_Stall.

## Structure
- pkg_tpu additions:
  - WB_FIFO_DEPTH=4
  - typedef wb_entry_t {logic remote; logic [3:0] offset; index_t idx; data_t data;}
  - enum fsm_wb_t {WB_IDLE, WB_ISSUE, WB_XFER}
- One sub-module: WB_FIFO. Parameterised depth storage of wb_entry_t with push/pop, count, and full/empty flags.
- FSM and offset arithmetic live in wb_sender_v.

## Test plan
- Reset, then 3 local pushes (idx 1,2,3; data 0xA,0xB,0xC) on consecutive cycles, no stall -> O_WB_Req high 3 consecutive cycles starting 1 cycle after the first push; indices 1,2,3 in order.
- Local push with I_Stall held 4 cycles -> O_WB_Req stays 0 while stalled; one pulse in the cycle I_Stall drops; FIFO empty afterwards.
- LANE_ID=14, remote push offset 3, I_Lane_Ready low 5 cycles then high -> O_Lane_Valid high from push+2; O_Lane_Dst=1; fields stable throughout; pop on the Ready cycle; FSM returns to IDLE.
- Push 5 entries back-to-back with stall held (DEPTH=4) -> O_Full asserts after the 3rd push; 5th push dropped; O_Overflow=1 and sticky; after stall release exactly 4 O_WB_Req pulses.
- Interleaved local/remote/local entries with Ready delayed 2 cycles -> strict FIFO order preserved; the second local write does not issue until the remote transfer completes.
- Assert reset while in XFER with 2 entries queued -> next cycle all outputs 0, FSM IDLE, and no pending entries issue afterwards.
